// File: rtl/mosaic_pkg.sv
// Shared types and sizes for the mosaic stitching pipeline.
package mosaic_pkg;

  localparam int unsigned ROW_PIX   = 32;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ROW_IDX_W = 5;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rg_state_t;

endpackage

// File: rtl/residual_lane.sv
// One residual lane: cur/ref pixel to an unsigned 8-bit residual.
// RESIDUAL_ABS_EN selects |cur-ref|; otherwise clamp(cur-ref+128, 0, 255).
module residual_lane
  import mosaic_pkg::*;
(
  input  pix_t cur_pix,
  input  pix_t ref_pix,
  output pix_t res
);

`ifdef RESIDUAL_ABS_EN
  always_comb begin
    res = '0;
    if (cur_pix >= ref_pix) res = cur_pix - ref_pix;
    else                    res = ref_pix - cur_pix;
  end
`else
  logic [PIX_W+1:0] biased;
  logic [PIX_W+1:0] ref_ext;
  logic [PIX_W+1:0] diff;

  // Bias cur by 128 first so the subtraction underflows only when the result clamps to 0.
  always_comb begin
    biased  = {2'b00, cur_pix} + (PIX_W+2)'(128);
    ref_ext = {2'b00, ref_pix};
    diff    = biased - ref_ext;
    res     = '0;
    if (biased < ref_ext)          res = '0;
    else if (diff[PIX_W+1:PIX_W] != 2'b00) res = '1;
    else                           res = diff[PIX_W-1:0];
  end
`endif

endmodule

// File: rtl/residual_gen.sv
// Row-residual generator feeding the residual writeback stage.
// Build option RESIDUAL_ABS_EN switches lanes to absolute difference.
module residual_gen
  import mosaic_pkg::*;
#(
  parameter int unsigned POI_DEPTH = 4,
  parameter int unsigned POI_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  pix_t [ROW_PIX-1:0]             cur_row,
  input  pix_t [ROW_PIX-1:0]             ref_row,
  output logic                           wb_en,
  output logic [POI_DEPTH+POI_WIDTH-1:0] wb_poi_addr,
  output logic [ROW_IDX_W-1:0]           wb_row,
  output pix_t [ROW_PIX-1:0]             wb_residuals,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int unsigned ADDR_W = POI_DEPTH + POI_WIDTH;

  rg_state_t            state;
  logic [ADDR_W-1:0]    poi_cnt;
  logic [ROW_IDX_W-1:0] row_cnt;
  pix_t [ROW_PIX-1:0]   res_c;
  logic                 accept_c;
  logic                 last_row_c;
  logic                 last_poi_c;

  for (genvar i = 0; i < ROW_PIX; i++) begin : g_lane
    residual_lane u_lane (
      .cur_pix (cur_row[i]),
      .ref_pix (ref_row[i]),
      .res     (res_c[i])
    );
  end

  assign accept_c   = in_valid && in_ready;
  assign last_row_c = (row_cnt == ROW_IDX_W'(ROW_PIX - 1));
  assign last_poi_c = (poi_cnt == '1);

  // Frame sequencer; status flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      wb_en        <= 1'b0;
      wb_poi_addr  <= '0;
      wb_row       <= '0;
      wb_residuals <= '0;
      poi_cnt      <= '0;
      row_cnt      <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            poi_cnt    <= '0;
            row_cnt    <= '0;
          end
        end
        RUN: begin
          if (accept_c) begin
            wb_en        <= 1'b1;
            wb_poi_addr  <= poi_cnt;
            wb_row       <= row_cnt;
            wb_residuals <= res_c;
            row_cnt      <= row_cnt + ROW_IDX_W'(1);
            if (last_row_c) poi_cnt <= poi_cnt + ADDR_W'(1);
            if (last_row_c && last_poi_c) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_residual_gen.sv
// Self-checking bench for residual_gen: constant vector table plus a
// beat-count reference model driven by randomized rows and in_valid.
module tb_residual_gen;
  import mosaic_pkg::*;

  localparam int unsigned POI_DEPTH   = 4;
  localparam int unsigned POI_WIDTH   = 4;
  localparam int unsigned ADDR_W      = POI_DEPTH + POI_WIDTH;
  localparam int unsigned FRAME_BEATS = (1 << ADDR_W) * ROW_PIX;

  typedef pix_t [ROW_PIX-1:0] row_t;
  typedef struct {
    pix_t cur;
    pix_t refv;
    pix_t exp_res;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic              in_ready, wb_en, busy, frame_done;
  row_t              cur_row, ref_row, wb_residuals;
  logic [ADDR_W-1:0] wb_poi_addr;
  logic [4:0]        wb_row;

  residual_gen #(.POI_DEPTH(POI_DEPTH), .POI_WIDTH(POI_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .cur_row(cur_row), .ref_row(ref_row),
    .wb_en(wb_en), .wb_poi_addr(wb_poi_addr), .wb_row(wb_row),
    .wb_residuals(wb_residuals), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: 0 idle, 1 running, 2 frame done; m_k counts beats in frame.
  int   m_mode = 0;
  int   m_k = 0;
  int   acc_count = 0;
  int   en_count = 0;
  logic e_en = 1'b0;
  int   e_addr = 0;
  int   e_row = 0;
  row_t e_res = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d want %0d", name, act, exp);
    else passed++;
  endtask

  task automatic chk_row(input string name, input row_t act, input row_t exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else passed++;
  endtask

  function automatic row_t fill(input pix_t v);
    row_t r;
    for (int i = 0; i < int'(ROW_PIX); i++) r[i] = v;
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < int'(ROW_PIX); i++) r[i] = 8'($urandom);
    return r;
  endfunction

  function automatic row_t model_res(input row_t c, input row_t r);
    row_t o;
    for (int i = 0; i < int'(ROW_PIX); i++) begin
      int d;
      int v;
      d = int'(c[i]) - int'(r[i]);
`ifdef RESIDUAL_ABS_EN
      v = (d < 0) ? -d : d;
`else
      v = d + 128;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
`endif
      o[i] = 8'(v);
    end
    return o;
  endfunction

  // Drive one cycle, advance the model, then compare every output.
  task automatic cycle(input logic st, input logic v, input logic rs,
                       input row_t c, input row_t r);
    logic acc;
    start = st; in_valid = v; reset = rs; cur_row = c; ref_row = r;
    acc = !rs && (m_mode == 1) && v;
    if (rs) begin
      m_mode = 0; m_k = 0; e_en = 1'b0; e_addr = 0; e_row = 0; e_res = '0;
    end else begin
      e_en = acc;
      if (acc) begin
        acc_count++;
        e_addr = m_k / int'(ROW_PIX);
        e_row  = m_k % int'(ROW_PIX);
        e_res  = model_res(c, r);
        m_k++;
        if (m_k == int'(FRAME_BEATS)) begin m_mode = 2; m_k = 0; end
      end else if (st && m_mode != 1) begin
        m_mode = 1; m_k = 0;
      end
    end
    @(posedge clk); #1;
    if (wb_en === 1'b1) en_count++;
    chk("wb_en", int'(wb_en), int'(e_en));
    chk("in_ready", int'(in_ready), int'(m_mode == 1));
    chk("busy", int'(busy), int'(m_mode == 1));
    chk("frame_done", int'(frame_done), int'(m_mode == 2));
    chk("wb_poi_addr", int'(wb_poi_addr), e_addr);
    chk("wb_row", int'(wb_row), e_row);
    chk_row("wb_residuals", wb_residuals, e_res);
  endtask

  task automatic beat(input row_t c, input row_t r);
    cycle(1'b0, 1'b1, 1'b0, c, r);
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) cycle(1'b0, v, 1'b0, rand_row(), rand_row());
  endtask

  vec_t vecs[10];

  initial begin
`ifdef RESIDUAL_ABS_EN
    vecs = '{'{8'd200, 8'd50, 8'd150}, '{8'd10, 8'd100, 8'd90}, '{8'd77, 8'd77, 8'd0},
             '{8'd0, 8'd255, 8'd255}, '{8'd255, 8'd0, 8'd255}, '{8'd100, 8'd228, 8'd128},
             '{8'd100, 8'd227, 8'd127}, '{8'd226, 8'd99, 8'd127}, '{8'd227, 8'd99, 8'd128},
             '{8'd0, 8'd127, 8'd127}};
`else
    vecs = '{'{8'd200, 8'd50, 8'd255}, '{8'd10, 8'd100, 8'd38}, '{8'd77, 8'd77, 8'd128},
             '{8'd0, 8'd255, 8'd0}, '{8'd255, 8'd0, 8'd255}, '{8'd100, 8'd228, 8'd0},
             '{8'd100, 8'd227, 8'd1}, '{8'd226, 8'd99, 8'd255}, '{8'd227, 8'd99, 8'd255},
             '{8'd0, 8'd127, 8'd1}};
`endif

    // Reset, then idle with in_valid high: nothing may be accepted.
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    cycle(1'b0, 1'b1, 1'b1, '0, '0);
    idle(5, 1'b1);
    chk("reset_in_ready", int'(in_ready), 0);
    chk_row("reset_residuals", wb_residuals, '0);

    // Start coincident with in_valid: state change only.
    cycle(1'b1, 1'b1, 1'b0, fill(8'd1), fill(8'd2));
    chk("start_no_emit", int'(wb_en), 0);
    for (int i = 0; i < 10; i++) begin
      beat(fill(vecs[i].cur), fill(vecs[i].refv));
      chk("vec_en", int'(wb_en), 1);
      chk("vec_row", int'(wb_row), i);
      chk_row("vec_res", wb_residuals, fill(vecs[i].exp_res));
    end
    idle(3, 1'b0);
    chk_row("hold_res", wb_residuals, fill(vecs[9].exp_res));

    // start in RUN is ignored; then 33 back-to-back beats from a fresh frame.
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    chk("start_in_run_row", int'(wb_row), 9);
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 33; i++) beat(rand_row(), rand_row());
    chk("beat33_poi", int'(wb_poi_addr), 1);
    chk("beat33_row", int'(wb_row), 0);

    // Random in_valid: emitted count must equal accepted count.
    acc_count = 0; en_count = 0;
    for (int i = 0; i < 300; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, rand_row(), rand_row());
    chk("en_vs_accept", en_count, acc_count);

    // Reset at beat 100 discards the frame.
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 100; i++) beat(rand_row(), rand_row());
    cycle(1'b0, 1'b1, 1'b1, rand_row(), rand_row());
    chk("midreset_en", int'(wb_en), 0);
    en_count = 0;
    idle(6, 1'b1);
    chk("midreset_no_emit", en_count, 0);
    cycle(1'b1, 1'b1, 1'b0, rand_row(), rand_row());
    beat(rand_row(), rand_row());
    chk("restart_poi", int'(wb_poi_addr), 0);
    chk("restart_row", int'(wb_row), 0);

    // Full frame with random in_valid.
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    begin
      int budget;
      budget = 0;
      while (m_mode == 1 && budget < 40000) begin
        cycle(1'b0, ($urandom_range(0, 3) != 0), 1'b0, rand_row(), rand_row());
        budget++;
      end
      chk("frame_in_budget", int'(m_mode == 2), 1);
    end
    chk("last_en", int'(wb_en), 1);
    chk("last_poi", int'(wb_poi_addr), 255);
    chk("last_row", int'(wb_row), 31);
    chk("last_frame_done", int'(frame_done), 1);
    chk("last_in_ready", int'(in_ready), 0);
    idle(10, 1'b1);
    chk("done_in_ready", int'(in_ready), 0);
    cycle(1'b1, 1'b1, 1'b0, rand_row(), rand_row());
    chk("redo_busy", int'(busy), 1);
    beat(rand_row(), rand_row());
    chk("redo_poi", int'(wb_poi_addr), 0);
    chk("redo_row", int'(wb_row), 0);
    idle(4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
